// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers for the fifo_flow family.
//   ptr_w(depth) : bits needed for a pointer index 0..depth-1
//   cnt_w(depth) : bits needed for an occupancy count 0..depth
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: {phase, idx} pointer for a FIFO of arbitrary DEPTH.
//   clk      in   clock, rising edge
//   reset    in   asynchronous reset, active-low
//   clr_i    in   synchronous return to zero (wins over inc_i)
//   inc_i    in   advance the pointer by one entry
//   idx_o    out  entry index 0..DEPTH-1
//   phase_o  out  toggles each time idx_o wraps DEPTH-1 -> 0
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    inc_i,
    output logic [ptr_w(DEPTH)-1:0] idx_o,
    output logic                    phase_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [PW-1:0] idx_q, idx_d;
    logic          phase_q, phase_d;

    always_comb begin
        idx_d   = idx_q;
        phase_d = phase_q;
        if (clr_i) begin
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (inc_i) begin
            // Explicit wrap so non-power-of-2 depths never index past the array.
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                phase_d = ~phase_q;
            end else begin
                idx_d = idx_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign idx_o   = idx_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/fifo_flow.sv
// fifo_flow: single-clock valid/ready FIFO with any DEPTH, optional output
// register, occupancy count, almost flags, sticky overflow and flush.
//   clk             in   clock, rising edge
//   reset           in   asynchronous reset, active-low
//   clr_i           in   synchronous flush (pointers, count, out_vld_o, ovf_o)
//   in_vld_i        in   write request
//   in_data_i       in   write data
//   in_rdy_o        out  space available (~full_o)
//   out_vld_o       out  head entry valid on out_data_o
//   out_data_o      out  head data
//   out_rdy_i       in   consumer accepts head
//   count_o         out  entries held, including the output register
//   full_o          out  count_o == DEPTH
//   empty_o         out  count_o == 0
//   almost_full_o   out  count_o >= AF_LVL
//   almost_empty_o  out  count_o <= AE_LVL
//   ovf_o           out  sticky: write attempted while full
module fifo_flow
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int OUT_REG = 0,
    parameter int AF_LVL  = DEPTH - 1,
    parameter int AE_LVL  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    in_vld_i,
    input  logic [WIDTH-1:0]        in_data_i,
    output logic                    in_rdy_o,
    output logic                    out_vld_o,
    output logic [WIDTH-1:0]        out_data_o,
    input  logic                    out_rdy_i,
    output logic [cnt_w(DEPTH)-1:0] count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic                    ovf_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_idx, rd_idx;
    logic          wr_phase, rd_phase;
    logic          mem_empty;
    logic          wr_en, pop, rd_inc;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    // Flags decode the count register only, so in_rdy_o never sees out_rdy_i.
    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign in_rdy_o       = ~full_o;
    assign count_o        = count_q;
    assign ovf_o          = ovf_q;

    assign mem_empty = (wr_idx == rd_idx) && (wr_phase == rd_phase);

    assign wr_en = in_vld_i & in_rdy_o & ~clr_i;
    assign pop   = out_vld_o & out_rdy_i & ~clr_i;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_i),
        .inc_i   (wr_en),
        .idx_o   (wr_idx),
        .phase_o (wr_phase)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_i),
        .inc_i   (rd_inc),
        .idx_o   (rd_idx),
        .phase_o (rd_phase)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= in_data_i;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_comb_out
            // With no output register every entry lives in memory, so this
            // is the same as ~empty_o.
            assign out_vld_o  = ~mem_empty;
            assign out_data_o = mem_q[rd_idx];
            assign rd_inc     = pop;
        end else begin : g_reg_out
            logic             out_vld_q, out_vld_d;
            logic [WIDTH-1:0] out_data_q;
            logic             load;

            // Refill the register when it is empty or being drained this cycle.
            assign load = ~clr_i & ~mem_empty & (~out_vld_q | pop);

            always_comb begin
                out_vld_d = out_vld_q;
                if (clr_i) begin
                    out_vld_d = 1'b0;
                end else if (load) begin
                    out_vld_d = 1'b1;
                end else if (pop) begin
                    out_vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_vld_q  <= 1'b0;
                    out_data_q <= '0;
                end else begin
                    out_vld_q <= out_vld_d;
                    if (load) begin
                        out_data_q <= mem_q[rd_idx];
                    end
                end
            end

            assign out_vld_o  = out_vld_q;
            assign out_data_o = out_data_q;
            assign rd_inc     = load;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (in_vld_i && full_o) begin
                ovf_d = 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !wr_en) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fifo_flow.sv
// tb_fifo_flow: directed bench for fifo_flow, DEPTH=5, WIDTH=8, AF_LVL=4,
// AE_LVL=1. Instance 0 has OUT_REG=0, instance 1 has OUT_REG=1; every test
// task takes the instance number and is run once per instance.
module tb_fifo_flow;

    logic       clk;
    logic       reset     [2];
    logic       clr       [2];
    logic       in_vld    [2];
    logic [7:0] in_data   [2];
    logic       in_rdy    [2];
    logic       out_vld   [2];
    logic [7:0] out_data  [2];
    logic       out_rdy   [2];
    logic [2:0] count     [2];
    logic       full      [2];
    logic       empty     [2];
    logic       afull     [2];
    logic       aempty    [2];
    logic       ovf       [2];

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q [$];

    fifo_flow #(.WIDTH(8), .DEPTH(5), .OUT_REG(0), .AF_LVL(4), .AE_LVL(1)) u_dut0 (
        .clk(clk), .reset(reset[0]), .clr_i(clr[0]), .in_vld_i(in_vld[0]),
        .in_data_i(in_data[0]), .in_rdy_o(in_rdy[0]), .out_vld_o(out_vld[0]),
        .out_data_o(out_data[0]), .out_rdy_i(out_rdy[0]), .count_o(count[0]),
        .full_o(full[0]), .empty_o(empty[0]), .almost_full_o(afull[0]),
        .almost_empty_o(aempty[0]), .ovf_o(ovf[0])
    );

    fifo_flow #(.WIDTH(8), .DEPTH(5), .OUT_REG(1), .AF_LVL(4), .AE_LVL(1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .clr_i(clr[1]), .in_vld_i(in_vld[1]),
        .in_data_i(in_data[1]), .in_rdy_o(in_rdy[1]), .out_vld_o(out_vld[1]),
        .out_data_o(out_data[1]), .out_rdy_i(out_rdy[1]), .count_o(count[1]),
        .full_o(full[1]), .empty_o(empty[1]), .almost_full_o(afull[1]),
        .almost_empty_o(aempty[1]), .ovf_o(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops up to n entries into got_q, bounded by a cycle budget.
    task automatic drain(input int r, input int n);
        got_q = {};
        out_rdy[r] = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < n; c++) begin
            if (out_vld[r]) got_q.push_back(out_data[r]);
            step();
        end
        out_rdy[r] = 1'b0;
    endtask

    task automatic fill(input int r, input int n, input logic [7:0] base);
        out_rdy[r] = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_vld[r]  = 1'b1;
            in_data[r] = base + 8'(i);
            step();
        end
        in_vld[r] = 1'b0;
    endtask

    task automatic test_reset(input int r);
        reset[r] = 1'b0;
        #2;
        checks++;
        if ({count[r], empty[r], aempty[r], full[r], afull[r], in_rdy[r], out_vld[r], ovf[r]}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset[%0d]: count=%0d empty=%b ae=%b full=%b af=%b rdy=%b vld=%b ovf=%b, need 0 1 1 0 0 1 0 0",
                     r, count[r], empty[r], aempty[r], full[r], afull[r], in_rdy[r], out_vld[r], ovf[r]);
        end
        reset[r] = 1'b1;
        step();
    endtask

    task automatic test_single(input int r);
        in_vld[r]  = 1'b1;
        in_data[r] = 8'h11;
        step();
        in_vld[r]  = 1'b0;
        checks++;
        if (count[r] !== 3'd1 || aempty[r] !== 1'b1) begin
            errors++;
            $display("FAIL single_count[%0d]: count=%0d ae=%b, need 1 1", r, count[r], aempty[r]);
        end
        if (r == 1) begin
            checks++;
            if (out_vld[r] !== 1'b0) begin
                errors++;
                $display("FAIL single_early[%0d]: out_vld=%b, need 0", r, out_vld[r]);
            end
            step();
        end
        checks++;
        if (out_vld[r] !== 1'b1 || out_data[r] !== 8'h11) begin
            errors++;
            $display("FAIL single_out[%0d]: vld=%b data=%h, need 1 11", r, out_vld[r], out_data[r]);
        end
        drain(r, 1);
        checks++;
        if (empty[r] !== 1'b1 || out_vld[r] !== 1'b0) begin
            errors++;
            $display("FAIL single_drain[%0d]: empty=%b vld=%b, need 1 0", r, empty[r], out_vld[r]);
        end
    endtask

    task automatic test_fill_ovf(input int r);
        out_rdy[r] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_vld[r]  = 1'b1;
            in_data[r] = 8'(i);
            step();
            checks++;
            if (count[r] !== 3'(i) || afull[r] !== (i >= 4) || full[r] !== (i == 5)
                || in_rdy[r] !== (i != 5)) begin
                errors++;
                $display("FAIL fill_flags[%0d] i=%0d: count=%0d af=%b full=%b rdy=%b", r, i,
                         count[r], afull[r], full[r], in_rdy[r]);
            end
        end
        in_data[r] = 8'hFF;
        step();
        in_vld[r] = 1'b0;
        checks++;
        if (ovf[r] !== 1'b1 || count[r] !== 3'd5) begin
            errors++;
            $display("FAIL ovf_set[%0d]: ovf=%b count=%0d, need 1 5", r, ovf[r], count[r]);
        end
        drain(r, 6);
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL ovf_drain_len[%0d]: got %0d entries, need 5", r, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++;
            if (got_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL ovf_drain_data[%0d] #%0d: got %h need %h", r, i, got_q[i], 8'(i + 1));
            end
        end
        checks++;
        if (ovf[r] !== 1'b1 || empty[r] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky[%0d]: ovf=%b empty=%b, need 1 1", r, ovf[r], empty[r]);
        end
    endtask

    task automatic test_clr(input int r);
        fill(r, 3, 8'h50);
        in_vld[r]  = 1'b1;
        in_data[r] = 8'h77;
        out_rdy[r] = 1'b1;
        clr[r]     = 1'b1;
        step();
        clr[r]     = 1'b0;
        in_vld[r]  = 1'b0;
        out_rdy[r] = 1'b0;
        checks++;
        if (count[r] !== 3'd0 || empty[r] !== 1'b1 || out_vld[r] !== 1'b0 || ovf[r] !== 1'b0) begin
            errors++;
            $display("FAIL clr[%0d]: count=%0d empty=%b vld=%b ovf=%b, need 0 1 0 0",
                     r, count[r], empty[r], out_vld[r], ovf[r]);
        end
        step();
        step();
        checks++;
        if (out_vld[r] !== 1'b0 || count[r] !== 3'd0) begin
            errors++;
            $display("FAIL clr_hold[%0d]: vld=%b count=%0d, need 0 0", r, out_vld[r], count[r]);
        end
    endtask

    task automatic test_stream(input int r);
        int wi = 0;
        int bad_cnt = 0;
        got_q = {};
        out_rdy[r] = 1'b1;
        for (int c = 0; c < 100 && got_q.size() < 23; c++) begin
            in_vld[r]  = (wi < 23);
            in_data[r] = 8'(8'h20 + wi);
            if (c >= 1 + r && wi < 23 && count[r] !== 3'(1 + r)) bad_cnt++;
            if (out_vld[r]) got_q.push_back(out_data[r]);
            step();
            if (in_vld[r]) wi++;
        end
        in_vld[r]  = 1'b0;
        out_rdy[r] = 1'b0;
        checks++;
        if (got_q.size() != 23) begin
            errors++;
            $display("FAIL stream_len[%0d]: got %0d items, need 23", r, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 23; i++) begin
            checks++;
            if (got_q[i] !== 8'(8'h20 + i)) begin
                errors++;
                $display("FAIL stream_data[%0d] #%0d: got %h need %h", r, i, got_q[i], 8'(8'h20 + i));
            end
        end
        checks++;
        if (bad_cnt != 0) begin
            errors++;
            $display("FAIL stream_count[%0d]: %0d cycles with count != %0d", r, bad_cnt, 1 + r);
        end
        checks++;
        if (empty[r] !== 1'b1) begin
            errors++;
            $display("FAIL stream_empty[%0d]: empty=%b, need 1", r, empty[r]);
        end
    endtask

    task automatic test_full_rw(input int r);
        fill(r, 5, 8'h31);
        checks++;
        if (full[r] !== 1'b1 || out_vld[r] !== 1'b1) begin
            errors++;
            $display("FAIL frw_full[%0d]: full=%b vld=%b, need 1 1", r, full[r], out_vld[r]);
        end
        in_vld[r]  = 1'b1;
        in_data[r] = 8'hA5;
        out_rdy[r] = 1'b1;
        step();
        out_rdy[r] = 1'b0;
        checks++;
        if (count[r] !== 3'd4 || in_rdy[r] !== 1'b1) begin
            errors++;
            $display("FAIL frw_pop[%0d]: count=%0d rdy=%b, need 4 1", r, count[r], in_rdy[r]);
        end
        step();
        in_vld[r] = 1'b0;
        checks++;
        if (count[r] !== 3'd5) begin
            errors++;
            $display("FAIL frw_write[%0d]: count=%0d, need 5", r, count[r]);
        end
        drain(r, 5);
        checks++;
        if (got_q.size() != 5 || got_q[0] !== 8'h32 || got_q[3] !== 8'h35 || got_q[4] !== 8'hA5) begin
            errors++;
            $display("FAIL frw_order[%0d]: got %0d entries first=%h fourth=%h last=%h, need 5 32 35 a5",
                     r, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h0,
                     (got_q.size() > 3) ? got_q[3] : 8'h0, (got_q.size() > 4) ? got_q[4] : 8'h0);
        end
    endtask

    task automatic test_async_reset(input int r);
        fill(r, 3, 8'h60);
        #2;
        reset[r] = 1'b0;
        #1;
        checks++;
        if (count[r] !== 3'd0 || out_vld[r] !== 1'b0 || empty[r] !== 1'b1
            || in_rdy[r] !== 1'b1 || ovf[r] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset[%0d]: count=%0d vld=%b empty=%b rdy=%b ovf=%b, need 0 0 1 1 0",
                     r, count[r], out_vld[r], empty[r], in_rdy[r], ovf[r]);
        end
        #1;
        reset[r] = 1'b1;
        out_rdy[r] = 1'b1;
        step();
        step();
        step();
        out_rdy[r] = 1'b0;
        checks++;
        if (out_vld[r] !== 1'b0 || count[r] !== 3'd0) begin
            errors++;
            $display("FAIL async_release[%0d]: vld=%b count=%0d, need 0 0", r, out_vld[r], count[r]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i]   = 1'b1;
            clr[i]     = 1'b0;
            in_vld[i]  = 1'b0;
            in_data[i] = 8'h00;
            out_rdy[i] = 1'b0;
        end
        #1;
        for (int r = 0; r < 2; r++) begin
            test_reset(r);
            test_single(r);
            test_fill_ovf(r);
            test_clr(r);
            test_stream(r);
            test_full_rw(r);
            test_async_reset(r);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
